// File: rtl/maxpool_2x2_stream_pkg.sv
// -----------------------------------------------------------------------------
// maxpool_2x2_stream_pkg
//   Shared definitions for the pooling datapath:
//     - number-format encodings for the ARITH_TYPE parameter
//     - greater_eq(): the ordering used by every max/ReLU style stage
//   Ports: none (package).
// -----------------------------------------------------------------------------
package maxpool_2x2_stream_pkg;

  // Number formats carried on the sample bus.
  localparam int ARITH_FP32 = 0;  // IEEE-754 single precision bit patterns
  localparam int ARITH_INT  = 1;  // signed two's complement

  // Widest word greater_eq() can order; narrower words are zero-extended by
  // the caller and the real width is passed in.
  localparam int GE_MAX_W = 64;

  typedef logic [GE_MAX_W-1:0] ge_word_t;

  // Returns 1 when a should be chosen over b, so ties keep the first operand.
  //   ARITH_INT : signed compare.
  //   ARITH_FP32: sign-magnitude order on the raw bits; +0 and -0 compare
  //               equal (first operand wins). NaNs get no special treatment
  //               and simply fall into the same bitwise ordering.
  function automatic logic greater_eq(input ge_word_t a,
                                      input ge_word_t b,
                                      input int       arith_type,
                                      input int       width);
    ge_word_t sign_mask;
    ge_word_t mag_mask;
    ge_word_t a_mag;
    ge_word_t b_mag;
    logic     a_neg;
    logic     b_neg;
    logic     ge;
    sign_mask = ge_word_t'(1) << (width - 1);
    mag_mask  = ~({GE_MAX_W{1'b1}} << (width - 1));
    a_neg     = |(a & sign_mask);
    b_neg     = |(b & sign_mask);
    a_mag     = a & mag_mask;
    b_mag     = b & mag_mask;
    if (a_neg != b_neg) begin
      // Differing signs: the non-negative operand wins in both formats.
      ge = b_neg;
      // Except FP +0 / -0, which are equal, so the first operand is kept.
      if ((arith_type == ARITH_FP32) && (a_mag == '0) && (b_mag == '0)) begin
        ge = 1'b1;
      end
    end else if (arith_type == ARITH_INT) begin
      // Same sign in two's complement: the low bits order directly.
      ge = (a_mag >= b_mag);
    end else if (!a_neg) begin
      ge = (a_mag >= b_mag);
    end else begin
      // Both FP negative: the smaller magnitude is the larger value.
      ge = (a_mag <= b_mag);
    end
    return ge;
  endfunction

endpackage

// File: rtl/maxpool_2x2_stream_if.sv
// -----------------------------------------------------------------------------
// maxpool_2x2_stream_if
//   Sample stream into and pooled stream out of the max-pool stage.
//
//   Handshake: valid-only, no backpressure. A word is transferred on every
//   rising clock edge where its valid is high; the receiver must take it.
//   pool_valid_out and frame_done are single-cycle pulses. frame_clear is a
//   synchronous restart that overrides pool_valid_in in the same cycle.
//
//   Signals:
//     pool_data_in   [DATA_WIDTH] convolution output sample
//     pool_valid_in               pool_data_in valid this cycle
//     frame_clear                 restart position counters
//     pool_data_out  [DATA_WIDTH] pooled maximum (holds when not valid)
//     pool_valid_out              pool_data_out valid pulse
//     frame_done                  pulse marking the end of a pooled frame
//   Modports: master = upstream/consumer side, slave = pooling stage.
// -----------------------------------------------------------------------------
interface maxpool_2x2_stream_if #(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] pool_data_in;
  logic                  pool_valid_in;
  logic                  frame_clear;
  logic [DATA_WIDTH-1:0] pool_data_out;
  logic                  pool_valid_out;
  logic                  frame_done;

  modport master (
    output pool_data_in,
    output pool_valid_in,
    output frame_clear,
    input  pool_data_out,
    input  pool_valid_out,
    input  frame_done
  );

  modport slave (
    input  pool_data_in,
    input  pool_valid_in,
    input  frame_clear,
    output pool_data_out,
    output pool_valid_out,
    output frame_done
  );

endinterface

// File: rtl/maxpool_2x2_stream_pool_max2.sv
// -----------------------------------------------------------------------------
// maxpool_2x2_stream_pool_max2
//   Combinational two-input maximum; a is returned on a tie.
//   Ports:
//     a, b     [DATA_WIDTH] operands (a has priority on ties)
//     max_out  [DATA_WIDTH] selected operand
// -----------------------------------------------------------------------------
module maxpool_2x2_stream_pool_max2
  import maxpool_2x2_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ARITH_TYPE = ARITH_FP32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] max_out
);

  ge_word_t a_ext;
  ge_word_t b_ext;
  logic     a_wins;

  always_comb begin
    a_ext                   = '0;
    b_ext                   = '0;
    a_ext[DATA_WIDTH-1:0]   = a;
    b_ext[DATA_WIDTH-1:0]   = b;
    a_wins                  = greater_eq(a_ext, b_ext, ARITH_TYPE, DATA_WIDTH);
    max_out                 = a_wins ? a : b;
  end

endmodule

// File: rtl/maxpool_2x2_stream.sv
// -----------------------------------------------------------------------------
// maxpool_2x2_stream
//   Streaming 2x2 / stride-2 max pooling of a raster-order OFM_SIZE x OFM_SIZE
//   map into a POOL_SIZE x POOL_SIZE map (POOL_SIZE = OFM_SIZE/2, floor).
//   Only one half-row buffer (POOL_SIZE words) plus a left-sample register are
//   kept; no frame storage.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset
//     pool   maxpool_2x2_stream_if.slave (sample stream in, pooled stream out)
//
//   Dataflow per accepted sample at (row, col):
//     even col          -> left register
//     odd col, even row -> line_buf[col/2] = max(left, sample)
//     odd col, odd row  -> out = max(line_buf[col/2], max(left, sample)),
//                          presented one cycle later
//   With odd OFM_SIZE the trailing row/column only advance the counters.
// -----------------------------------------------------------------------------
module maxpool_2x2_stream
  import maxpool_2x2_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OFM_SIZE   = 30,
  parameter int ARITH_TYPE = ARITH_FP32
) (
  input  logic                 clk,
  input  logic                 reset,
  maxpool_2x2_stream_if.slave  pool
);

  localparam int POOL_SIZE = OFM_SIZE / 2;
  localparam int CNT_W     = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OFM_SIZE - 1);
  localparam bit   ODD_SIZE = (OFM_SIZE % 2) == 1;

  // Position counters.
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;

  // Most recent even-column sample of the current row.
  logic [DATA_WIDTH-1:0] left_q, left_d;

  // Horizontal pair maxima of the last even row. Not reset: each entry is
  // written on the even row before the odd row reads it.
  logic [DATA_WIDTH-1:0] line_buf_q [POOL_SIZE];
  logic [DATA_WIDTH-1:0] line_buf_d [POOL_SIZE];

  // Output registers.
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  frame_done_q, frame_done_d;

  logic                  col_last;
  logic                  row_last;
  logic                  row_kept;
  logic [CNT_W-1:0]      half_col;
  logic [DATA_WIDTH-1:0] buf_rd;
  logic [DATA_WIDTH-1:0] pair_max;
  logic [DATA_WIDTH-1:0] quad_max;

  assign col_last = (col_q == LAST_IDX);
  assign row_last = (row_q == LAST_IDX);
  // For odd sizes the final row has no partner row and never feeds the buffer.
  assign row_kept = !(ODD_SIZE && row_last);
  assign half_col = col_q >> 1;

  // Buffer read port, decoded from the pair index.
  always_comb begin
    buf_rd = '0;
    for (int i = 0; i < POOL_SIZE; i++) begin
      if (half_col == CNT_W'(i)) begin
        buf_rd = line_buf_q[i];
      end
    end
  end

  // Horizontal pair: left register over the incoming sample on ties.
  maxpool_2x2_stream_pool_max2 #(
    .DATA_WIDTH (DATA_WIDTH),
    .ARITH_TYPE (ARITH_TYPE)
  ) u_max_h (
    .a       (left_q),
    .b       (pool.pool_data_in),
    .max_out (pair_max)
  );

  // Vertical combine: buffered upper pair over the lower pair on ties.
  maxpool_2x2_stream_pool_max2 #(
    .DATA_WIDTH (DATA_WIDTH),
    .ARITH_TYPE (ARITH_TYPE)
  ) u_max_v (
    .a       (buf_rd),
    .b       (pair_max),
    .max_out (quad_max)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    left_d       = left_q;
    line_buf_d   = line_buf_q;
    data_out_d   = data_out_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;

    if (pool.frame_clear) begin
      // Restart wins over a coincident sample; nothing is written.
      col_d = '0;
      row_d = '0;
    end else if (pool.pool_valid_in) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end

      if (!col_q[0]) begin
        // Also taken for the trailing column of an odd size; the next
        // sample (col 0) overwrites it before anything reads it.
        left_d = pool.pool_data_in;
      end else if (!row_q[0]) begin
        if (row_kept) begin
          for (int i = 0; i < POOL_SIZE; i++) begin
            if (half_col == CNT_W'(i)) begin
              line_buf_d[i] = pair_max;
            end
          end
        end
      end else begin
        data_out_d  = quad_max;
        valid_out_d = 1'b1;
      end

      // Last sample of the frame. For even sizes this is also the last
      // window, so the pulse lines up with its result; for odd sizes it is
      // a discarded trailing sample and the pulse stands alone.
      frame_done_d = col_last && row_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      left_q       <= '0;
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      left_q       <= left_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    line_buf_q <= line_buf_d;
  end

  assign pool.pool_data_out  = data_out_q;
  assign pool.pool_valid_out = valid_out_q;
  assign pool.frame_done     = frame_done_q;

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// -----------------------------------------------------------------------------
// tb_maxpool_2x2_stream
//   Four pooling stages of different size / number format share one input
//   stream. A frame-level reference model records each accepted sample at its
//   (row, col) and, when a 2x2 window completes or a frame ends, pushes the
//   expected event (cycle, valid, frame_done, data) for that stage. A monitor
//   compares every output pulse against the queues.
//     dut 0: OFM 4,  int      dut 1: OFM 4,  fp32
//     dut 2: OFM 5,  int      dut 3: OFM 30, fp32 (defaults)
// -----------------------------------------------------------------------------
module tb_maxpool_2x2_stream;
  import maxpool_2x2_stream_pkg::*;

  localparam int W    = 32;
  localparam int NDUT = 4;
  localparam int MAXN = 30;

  function automatic int ofm_of(input int d);
    case (d)
      0: return 4;
      1: return 4;
      2: return 5;
      default: return 30;
    endcase
  endfunction

  function automatic int arith_of(input int d);
    case (d)
      0: return ARITH_INT;
      1: return ARITH_FP32;
      2: return ARITH_INT;
      default: return ARITH_FP32;
    endcase
  endfunction

  typedef struct {
    int         cyc;
    bit         v;
    bit         fd;
    logic [W-1:0] d;
  } ev_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] din = '0;
  logic         vin = 1'b0;
  logic         clr = 1'b0;

  logic [W-1:0] dout  [NDUT];
  logic         vout  [NDUT];
  logic         fdone [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    maxpool_2x2_stream_if #(.DATA_WIDTH(W)) bus ();
    assign bus.pool_data_in  = din;
    assign bus.pool_valid_in = vin;
    assign bus.frame_clear   = clr;
    assign dout[g]           = bus.pool_data_out;
    assign vout[g]           = bus.pool_valid_out;
    assign fdone[g]          = bus.frame_done;

    maxpool_2x2_stream #(
      .DATA_WIDTH (W),
      .OFM_SIZE   (ofm_of(g)),
      .ARITH_TYPE (arith_of(g))
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .pool  (bus.slave)
    );
  end

  // ---------------- reference model ----------------
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  bit           stop_req = 1'b0;
  ev_t          exp_q [NDUT][$];
  logic [W-1:0] frm [NDUT][MAXN][MAXN];
  int           pos [NDUT];

  // Numeric value of a word: signed int, or sign-magnitude for fp32 bits
  // (+0 and -0 both map to 0). Ties keep the first operand.
  function automatic logic [W-1:0] ref_max(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input int arith);
    longint va;
    longint vb;
    if (arith == ARITH_INT) begin
      va = longint'($signed(a));
      vb = longint'($signed(b));
    end else begin
      va = a[W-1] ? -longint'(a[W-2:0]) : longint'(a[W-2:0]);
      vb = b[W-1] ? -longint'(b[W-2:0]) : longint'(b[W-2:0]);
    end
    return (va >= vb) ? a : b;
  endfunction

  initial begin
    int  n;
    int  r;
    int  c;
    int  p;
    bit  is_win;
    bit  is_last;
    ev_t ev;
    for (int d = 0; d < NDUT; d++) pos[d] = 0;
    forever begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < NDUT; d++) begin
        n = ofm_of(d);
        p = n / 2;
        if (reset) begin
          pos[d] = 0;
          exp_q[d].delete();
        end else if (clr) begin
          pos[d] = 0;
        end else if (vin) begin
          r = pos[d] / n;
          c = pos[d] % n;
          frm[d][r][c] = din;
          is_win  = (r % 2 == 1) && (c % 2 == 1) && (r < 2 * p) && (c < 2 * p);
          is_last = (pos[d] == n * n - 1);
          if (is_win || is_last) begin
            ev.cyc = cyc;
            ev.v   = is_win;
            ev.fd  = is_last;
            ev.d   = '0;
            if (is_win) begin
              ev.d = ref_max(ref_max(frm[d][r-1][c-1], frm[d][r-1][c], arith_of(d)),
                             ref_max(frm[d][r][c-1], din, arith_of(d)), arith_of(d));
            end
            exp_q[d].push_back(ev);
          end
          pos[d] = is_last ? 0 : pos[d] + 1;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    ev_t e;
    while (!stop_req) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (reset) begin
          checks++;
          if (dout[d] !== '0 || vout[d] !== 1'b0 || fdone[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_out dut%0d cyc %0d: got data %h valid %b done %b, want 0 0 0",
                     d, cyc, dout[d], vout[d], fdone[d]);
          end
        end else if (vout[d] || fdone[d]) begin
          checks++;
          if (exp_q[d].size() == 0) begin
            errors++;
            $display("FAIL unexpected_out dut%0d cyc %0d: got valid %b done %b data %h, want no event",
                     d, cyc, vout[d], fdone[d], dout[d]);
          end else begin
            e = exp_q[d].pop_front();
            if (e.cyc != cyc || vout[d] !== e.v || fdone[d] !== e.fd ||
                (e.v && dout[d] !== e.d)) begin
              errors++;
              $display("FAIL out_event dut%0d: got cyc %0d valid %b done %b data %h, want cyc %0d valid %b done %b data %h",
                       d, cyc, vout[d], fdone[d], dout[d], e.cyc, e.v, e.fd, e.d);
            end
          end
        end else if (exp_q[d].size() != 0 && exp_q[d][0].cyc <= cyc) begin
          checks++;
          errors++;
          e = exp_q[d].pop_front();
          $display("FAIL missed_event dut%0d cyc %0d: got nothing, want valid %b done %b data %h",
                   d, cyc, e.v, e.fd, e.d);
        end
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (exp_q[d].size() != 0) begin
        errors++;
        $display("FAIL drained dut%0d: got %0d pending events, want 0", d, exp_q[d].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: stimulus did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      vin = 1'b0;
      clr = 1'b0;
      din = $urandom;
    end
  endtask

  task automatic drive_sample(input logic [W-1:0] d, input int gap);
    drive_idle(gap);
    @(posedge clk);
    #1;
    vin = 1'b1;
    clr = 1'b0;
    din = d;
  endtask

  task automatic drive_clear();
    @(posedge clk);
    #1;
    clr = 1'b1;
    vin = 1'($urandom_range(0, 1));
    din = $urandom;
  endtask

  task automatic send_ramp(input int n_words, input int max_gap);
    for (int i = 0; i < n_words; i++) begin
      drive_sample(W'(i), $urandom_range(0, max_gap));
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    vin   = 1'b0;
    clr   = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    case ($urandom_range(0, 4))
      0: w = '0;
      1: w = 32'h8000_0000;
      2: begin
        w = W'($urandom_range(0, 15));
        w[W-1] = 1'($urandom_range(0, 1));
      end
      default: w = $urandom;
    endcase
    return w;
  endfunction

  // ---------------- stimulus ----------------
  logic [W-1:0] fpw [16];

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    drive_idle(2);

    // 4x4 ramp, continuous
    send_ramp(16, 0);
    drive_idle(3);

    // fp32 sign / zero windows in a 4x4 frame
    drive_clear();
    for (int i = 0; i < 16; i++) fpw[i] = rand_word();
    fpw[0] = 32'hBF80_0000; fpw[1] = 32'hC000_0000;
    fpw[4] = 32'h8000_0000; fpw[5] = 32'hBF00_0000;
    fpw[2] = 32'h0000_0000; fpw[3] = 32'h8000_0000;
    fpw[6] = 32'h8000_0000; fpw[7] = 32'h8000_0000;
    for (int i = 0; i < 16; i++) drive_sample(fpw[i], 0);
    drive_idle(3);

    // ramp with bubbles
    drive_clear();
    send_ramp(16, 3);
    drive_idle(3);

    // odd size: two back-to-back 5x5 frames
    drive_clear();
    send_ramp(25, 0);
    send_ramp(25, 0);
    drive_idle(3);

    // default size: two back-to-back 30x30 frames
    drive_clear();
    send_ramp(900, 0);
    send_ramp(900, 0);
    drive_idle(3);

    // frame_clear mid-frame, then a clean 4x4 ramp
    drive_clear();
    send_ramp(7, 0);
    drive_clear();
    send_ramp(16, 0);
    drive_idle(3);

    // async reset mid-frame, then a clean 4x4 ramp
    drive_clear();
    send_ramp(7, 0);
    drive_idle(2);
    pulse_reset();
    drive_idle(1);
    send_ramp(16, 0);
    drive_idle(3);

    // random words, random bubbles, occasional restarts
    drive_clear();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) drive_clear();
      drive_sample(rand_word(), $urandom_range(0, 2));
    end
    drive_idle(5);

    stop_req = 1'b1;
  end

endmodule
